instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, ALU and immediate width.
REQ-002 Parameter ADDR_W, default 8, instruction address width; must be <= DATA_W.
REQ-003 Parameter INSTR_W, default 18+DATA_W, instruction word width; derived, not overridden.
REQ-004 CLK  input  1  single clock, rising-edge.
REQ-005 RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 start  input  1  leave IDLE/HALT and begin fetch at `start_addr`.
REQ-007 start_addr  input  ADDR_W  restart address.
REQ-008 imem_req  output  1  fetch request.
REQ-009 imem_addr  output  ADDR_W  fetch address (equals PC).
REQ-010 imem_rdata  input  INSTR_W  instruction word.
REQ-011 imem_ack  input  1  rdata valid this cycle.
REQ-012 flags  input  8  core flag register.
REQ-013 exec_en  output  1  one-cycle strobe; decoded fields are valid.
REQ-014 ALU_INST, MEM_INST, JMP_INST  output  1 each  class flags.
REQ-015 MS  output  2  regbank mode select.
REQ-016 IRS  output  1  immediate/register select.
REQ-017 RS, AR, BS  output  3 each  target, A-side and B-side register selects.
REQ-018 OP  output  4  ALU opcode or branch condition.
REQ-019 IMM  output  DATA_W  immediate.
REQ-020 pc  output  ADDR_W  current PC.
REQ-021 halted  output  1  high in HALT.

Function
REQ-022 Word layout, MSB first: cls[1:0], op[3:0], ms[1:0], irs, rs[2:0], ar[2:0], bs[2:0], imm[DATA_W-1:0].
REQ-023 cls encoding: 00 ALU (ALU_INST=1, MEM_INST=1); 01 MOV (MEM_INST=1); 10 JMP (JMP_INST=1); 11 HALT.
REQ-024 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-025 IDLE: start moves the FSM to FETCH and sets pc=start_addr.
REQ-026 FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack; ack moves the FSM to EXEC and registers the decoded fields.
REQ-027 Latency from ack to exec_en is exactly 1 cycle; in a zero-wait-state loop, exec_en rises once every 2 cycles.
REQ-028 EXEC: exec_en=1 for exactly one cycle; all decoded outputs hold their values until the next EXEC.
REQ-029 EXEC, ALU or MOV: pc <= pc+1, modulo 2^ADDR_W (wraps to 0); next state FETCH.
REQ-030 EXEC, JMP with condition: taken if op[2:0]==3'b111; otherwise taken when flags[op[2:0]] XOR op[3] is 1.
REQ-031 Taken JMP: pc <= imm[ADDR_W-1:0]. Not taken: pc <= pc+1. Next state FETCH.
REQ-032 EXEC, HALT class: exec_en=0, ALU_INST=MEM_INST=JMP_INST=0, pc unchanged, next state HALT.
REQ-033 HALT: halted=1 and imem_req=0; start behaves as in IDLE.
REQ-034 start outside IDLE/HALT is ignored.
REQ-035 imem_ack outside FETCH is ignored.
REQ-036 flags are sampled in the EXEC cycle only.

Reset
REQ-037 RST asserted, at any time including mid-fetch, immediately forces: state IDLE, pc=0, imem_req=0, exec_en=0, all class flags 0, MS/IRS/RS/AR/BS/OP/IMM=0, halted=0.
REQ-038 The first rising CLK after RST deasserts performs no fetch unless start is high.

Structure
REQ-039 A shared package holds: cls encodings, the state enum, field bit offsets as functions of DATA_W, and the unconditional-jump code 3'b111.
REQ-040 Sub-module instr_decode: purely combinational, INSTR_W word to fields; instantiated once.

Verification
REQ-041 Reset, then start with start_addr=0x10, ack after 3 wait cycles -> imem_addr=0x10 held 4 cycles, exec_en one cycle later, pc=0x11.
REQ-042 JMP op=0111, imm=0x00 -> pc=0x00 regardless of flags.
REQ-043 JMP op=0010 with flags[2]=0 -> pc+1; same with flags[2]=1 -> pc=imm; op=1010 with flags[2]=1 -> pc+1.
REQ-044 pc=0xFF executing ALU ADD (op=0000, irs=1, imm=9) -> IMM=9, ALU_INST=1, pc wraps to 0x00.
REQ-045 HALT word -> halted=1, imem_req=0 for 20 cycles; start with start_addr=0x05 -> fetch at 0x05.
REQ-046 RST pulsed while imem_req=1, then ack arrives after release -> no exec_en, all outputs 0, state IDLE.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: class codes,
// FSM states, decoded-control payload and instruction-word field offsets.
package instr_sequencer_pkg;

  localparam int unsigned CLS_W  = 2;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned MS_W   = 2;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned CTRL_W = CLS_W + OP_W + MS_W + 1 + 3 * REG_W;

  // Branch condition code meaning "always taken"
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_MOV  = 2'b01,
    CLS_JMP  = 2'b10,
    CLS_HALT = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  // Control portion of a decoded instruction (immediate carried separately)
  typedef struct packed {
    cls_e              cls;
    logic [OP_W-1:0]   op;
    logic [MS_W-1:0]   ms;
    logic              irs;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  ar;
    logic [REG_W-1:0]  bs;
  } instr_ctrl_t;

  // Field LSB positions within the instruction word, as a function of DATA_W
  function automatic int unsigned bs_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned ar_lsb(input int unsigned data_w);
    return data_w + REG_W;
  endfunction

  function automatic int unsigned rs_lsb(input int unsigned data_w);
    return data_w + 2 * REG_W;
  endfunction

  function automatic int unsigned irs_bit(input int unsigned data_w);
    return data_w + 3 * REG_W;
  endfunction

  function automatic int unsigned ms_lsb(input int unsigned data_w);
    return data_w + 3 * REG_W + 1;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned data_w);
    return data_w + 3 * REG_W + 1 + MS_W;
  endfunction

  function automatic int unsigned cls_lsb(input int unsigned data_w);
    return data_w + 3 * REG_W + 1 + MS_W + OP_W;
  endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational split of an instruction word into control fields and immediate.
module instr_decode
  import instr_sequencer_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned INSTR_W = CTRL_W + DATA_W
) (
  input  logic [INSTR_W-1:0] word,
  output instr_ctrl_t        ctrl,
  output logic [DATA_W-1:0]  imm
);

  localparam int unsigned BS_LSB  = bs_lsb(DATA_W);
  localparam int unsigned AR_LSB  = ar_lsb(DATA_W);
  localparam int unsigned RS_LSB  = rs_lsb(DATA_W);
  localparam int unsigned IRS_BIT = irs_bit(DATA_W);
  localparam int unsigned MS_LSB  = ms_lsb(DATA_W);
  localparam int unsigned OP_LSB  = op_lsb(DATA_W);
  localparam int unsigned CLS_LSB = cls_lsb(DATA_W);

  // Field extraction
  always_comb begin
    ctrl.cls = cls_e'(word[CLS_LSB +: CLS_W]);
    ctrl.op  = word[OP_LSB +: OP_W];
    ctrl.ms  = word[MS_LSB +: MS_W];
    ctrl.irs = word[IRS_BIT];
    ctrl.rs  = word[RS_LSB +: REG_W];
    ctrl.ar  = word[AR_LSB +: REG_W];
    ctrl.bs  = word[BS_LSB +: REG_W];
    imm      = word[DATA_W-1:0];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/branch sequencer: fetches a word at pc, presents the decoded
// fields with a one-cycle exec_en strobe, then advances or branches.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned ADDR_W  = 8,
  localparam int unsigned INSTR_W = CTRL_W + DATA_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic [7:0]         flags,
  output logic               exec_en,
  output logic               ALU_INST,
  output logic               MEM_INST,
  output logic               JMP_INST,
  output logic [1:0]         MS,
  output logic               IRS,
  output logic [2:0]         RS,
  output logic [2:0]         AR,
  output logic [2:0]         BS,
  output logic [3:0]         OP,
  output logic [DATA_W-1:0]  IMM,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  state_e             state_q;
  state_e             state_d;
  cls_e               cls_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  pc_inc_c;
  logic               req_d;
  logic               exec_d;
  logic               halted_d;
  logic               load_c;
  logic               taken_c;
  logic [2:0]         cond_c;
  instr_ctrl_t        dec_ctrl;
  logic [DATA_W-1:0]  dec_imm;

  instr_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .word (imem_rdata),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign imem_addr = pc;
  assign pc_inc_c  = pc + ADDR_W'(1);

  // Branch condition: code 111 always taken, else selected flag xor invert bit
  always_comb begin
    cond_c  = OP[2:0];
    taken_c = (cond_c == COND_ALWAYS) | (flags[cond_c] ^ OP[3]);
  end

  // Next-state, next-pc and strobe decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    exec_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_addr;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_EXEC;
          load_c  = 1'b1;
          exec_d  = (dec_ctrl.cls != CLS_HALT);
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_JMP: begin
            pc_d    = taken_c ? IMM[ADDR_W-1:0] : pc_inc_c;
            state_d = ST_FETCH;
          end
          CLS_HALT: begin
            state_d = ST_HALT;
          end
          default: begin
            pc_d    = pc_inc_c;
            state_d = ST_FETCH;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    req_d    = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  // State, pc and registered control outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      pc       <= '0;
      imem_req <= 1'b0;
      exec_en  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      imem_req <= req_d;
      exec_en  <= exec_d;
      halted   <= halted_d;
    end
  end

  // Decoded-field registers, loaded on fetch acknowledge and held until the next
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cls_q    <= CLS_ALU;
      ALU_INST <= 1'b0;
      MEM_INST <= 1'b0;
      JMP_INST <= 1'b0;
      MS       <= '0;
      IRS      <= 1'b0;
      RS       <= '0;
      AR       <= '0;
      BS       <= '0;
      OP       <= '0;
      IMM      <= '0;
    end else if (load_c) begin
      cls_q    <= dec_ctrl.cls;
      ALU_INST <= (dec_ctrl.cls == CLS_ALU);
      MEM_INST <= (dec_ctrl.cls == CLS_ALU) | (dec_ctrl.cls == CLS_MOV);
      JMP_INST <= (dec_ctrl.cls == CLS_JMP);
      MS       <= dec_ctrl.ms;
      IRS      <= dec_ctrl.irs;
      RS       <= dec_ctrl.rs;
      AR       <= dec_ctrl.ar;
      BS       <= dec_ctrl.bs;
      OP       <= dec_ctrl.op;
      IMM      <= dec_imm;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed corner sequences, a
// table of single-instruction vectors, and a random program run against an
// instruction-level reference interpreter.
module tb_instr_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 18 + DW;
  localparam int NVEC  = 10;
  localparam int NRAND = 300;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic [7:0]    flags = '0;
  logic          exec_en, ALU_INST, MEM_INST, JMP_INST, IRS, halted;
  logic [1:0]    MS;
  logic [2:0]    RS, AR, BS;
  logic [3:0]    OP;
  logic [DW-1:0] IMM;
  logic [AW-1:0] pc;

  int errors = 0;
  int checks = 0;

  instr_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .flags(flags), .exec_en(exec_en),
    .ALU_INST(ALU_INST), .MEM_INST(MEM_INST), .JMP_INST(JMP_INST),
    .MS(MS), .IRS(IRS), .RS(RS), .AR(AR), .BS(BS), .OP(OP), .IMM(IMM),
    .pc(pc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] pc0;
    logic [1:0] cls;
    logic [3:0] op;
    logic       irs;
    logic [7:0] imm;
    logic [7:0] flg;
    logic [7:0] exp_pc;
    logic [2:0] exp_class;  // {ALU_INST, MEM_INST, JMP_INST}
  } vec_t;

  vec_t vecs [NVEC];
  logic [IW-1:0] mem [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  function automatic logic [IW-1:0] mk(input logic [1:0] cls, input logic [3:0] op,
                                       input logic [1:0] ms, input logic irs,
                                       input logic [2:0] rs, input logic [2:0] ar,
                                       input logic [2:0] bs, input logic [7:0] imm);
    return {cls, op, ms, irs, rs, ar, bs, imm};
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({imem_req, exec_en, ALU_INST, MEM_INST, JMP_INST, MS, IRS, RS, AR, BS,
                OP, IMM, pc, halted});
  endfunction

  function automatic logic [63:0] dut_fields();
    return 64'({ALU_INST, MEM_INST, JMP_INST, MS, IRS, RS, AR, BS, OP, IMM});
  endfunction

  // Reference: what the decoded outputs should show for a fetched word
  function automatic logic [63:0] model_fields(input logic [IW-1:0] w);
    logic [2:0] cf;
    case (w[25:24])
      2'd0:    cf = 3'b110;
      2'd1:    cf = 3'b010;
      2'd2:    cf = 3'b001;
      default: cf = 3'b000;
    endcase
    return 64'({cf, w[19:18], w[17], w[16:14], w[13:11], w[10:8], w[23:20], w[7:0]});
  endfunction

  // Reference: pc after executing word w at address p with flags f
  function automatic logic [7:0] model_next_pc(input logic [7:0] p, input logic [IW-1:0] w,
                                               input logic [7:0] f);
    int cond;
    bit inv;
    bit flag_bit;
    if (w[25:24] == 2'd2) begin
      cond     = int'(w[22:20]);
      inv      = w[23];
      flag_bit = ((int'(f) >> cond) & 1) == 1;
      if (cond == 7 || (flag_bit != inv)) return w[7:0];
    end
    return 8'((int'(p) + 1) % 256);
  endfunction

  initial begin
    logic [IW-1:0] w;
    logic [7:0]    mpc;
    logic [7:0]    f;
    logic [7:0]    nxt;
    int            waits;

    vecs[0] = '{8'hFF, 2'b00, 4'b0000, 1'b1, 8'h09, 8'h00, 8'h00, 3'b110};
    vecs[1] = '{8'h20, 2'b01, 4'b0101, 1'b0, 8'h3C, 8'hFF, 8'h21, 3'b010};
    vecs[2] = '{8'h40, 2'b10, 4'b0111, 1'b0, 8'h00, 8'h00, 8'h00, 3'b001};
    vecs[3] = '{8'h41, 2'b10, 4'b0111, 1'b0, 8'h00, 8'hFF, 8'h00, 3'b001};
    vecs[4] = '{8'h30, 2'b10, 4'b0010, 1'b0, 8'h80, 8'h00, 8'h31, 3'b001};
    vecs[5] = '{8'h30, 2'b10, 4'b0010, 1'b0, 8'h80, 8'h04, 8'h80, 3'b001};
    vecs[6] = '{8'h30, 2'b10, 4'b1010, 1'b0, 8'h80, 8'h04, 8'h31, 3'b001};
    vecs[7] = '{8'h30, 2'b10, 4'b1010, 1'b0, 8'h80, 8'h00, 8'h80, 3'b001};
    vecs[8] = '{8'h10, 2'b10, 4'b1111, 1'b0, 8'h77, 8'h00, 8'h77, 3'b001};
    vecs[9] = '{8'hFF, 2'b10, 4'b0101, 1'b1, 8'h12, 8'h20, 8'h12, 3'b001};

    // Reset state, and no fetch after release without start
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    chk("idle_no_fetch", 64'({imem_req, exec_en, halted}), 64'd0);

    // Fetch at 0x10 with three wait states; start during fetch is ignored
    start = 1'b1;
    start_addr = 8'h10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", 64'(imem_req), 64'd1);
      chk("wait_addr", 64'(imem_addr), 64'h10);
      chk("wait_no_exec", 64'(exec_en), 64'd0);
      if (i == 1) begin
        start = 1'b1;
        start_addr = 8'h77;
      end
      if (i == 3) begin
        imem_rdata = mk(2'b00, 4'h3, 2'b10, 1'b0, 3'd1, 3'd2, 3'd3, 8'hA5);
        imem_ack = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    imem_ack = 1'b0;
    chk("first_exec_en", 64'(exec_en), 64'd1);
    chk("first_fields", dut_fields(),
        model_fields(mk(2'b00, 4'h3, 2'b10, 1'b0, 3'd1, 3'd2, 3'd3, 8'hA5)));
    tick();
    chk("first_exec_one_cycle", 64'(exec_en), 64'd0);
    chk("first_pc_inc", 64'(pc), 64'h11);
    chk("refetch_req", 64'(imem_req), 64'd1);

    // HALT word: halted and no requests, ack ignored, restart at 0x05
    imem_rdata = mk(2'b11, 4'hA, 2'b01, 1'b1, 3'd5, 3'd2, 3'd6, 8'h55);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("halt_no_exec", 64'({exec_en, ALU_INST, MEM_INST, JMP_INST}), 64'd0);
    tick();
    chk("halt_enter", 64'({halted, imem_req}), 64'b10);
    chk("halt_pc", 64'(pc), 64'h11);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("halt_hold", 64'({halted, imem_req, exec_en}), 64'b100);
    end
    imem_ack = 1'b0;
    start = 1'b1;
    start_addr = 8'h05;
    tick();
    start = 1'b0;
    chk("restart_req", 64'({imem_req, halted}), 64'b10);
    chk("restart_addr", 64'(imem_addr), 64'h05);

    // Asynchronous reset mid-fetch, then late ack must be ignored
    #2;
    RST = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    tick();
    RST = 1'b0;
    imem_rdata = mk(2'b00, 4'h1, 2'b11, 1'b1, 3'd7, 3'd7, 3'd7, 8'hFF);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_ack_ignored", all_outs(), 64'd0);
    end
    imem_ack = 1'b0;

    // Table of single-instruction vectors
    for (int i = 0; i < NVEC; i++) begin
      reset_dut();
      start = 1'b1;
      start_addr = vecs[i].pc0;
      tick();
      start = 1'b0;
      chk("vec_addr", 64'(imem_addr), 64'(vecs[i].pc0));
      imem_rdata = mk(vecs[i].cls, vecs[i].op, 2'(i), vecs[i].irs, 3'(i), 3'(i + 1),
                      3'(i + 2), vecs[i].imm);
      imem_ack = 1'b1;
      flags = ~vecs[i].flg;
      tick();
      imem_ack = 1'b0;
      chk("vec_exec_en", 64'(exec_en), 64'd1);
      chk("vec_class", 64'({ALU_INST, MEM_INST, JMP_INST}), 64'(vecs[i].exp_class));
      chk("vec_fields", 64'({MS, IRS, RS, AR, BS, OP, IMM}),
          64'({2'(i), vecs[i].irs, 3'(i), 3'(i + 1), 3'(i + 2), vecs[i].op, vecs[i].imm}));
      flags = vecs[i].flg;
      tick();
      chk("vec_next_pc", 64'(pc), 64'(vecs[i].exp_pc));
      chk("vec_exec_drop", 64'(exec_en), 64'd0);
    end

    // Random program against the reference interpreter
    for (int a = 0; a < 256; a++) begin
      w = IW'($urandom);
      if (w[25:24] == 2'b11) w[25:24] = 2'($urandom_range(0, 2));
      mem[a] = w;
    end
    reset_dut();
    mpc = 8'($urandom);
    start = 1'b1;
    start_addr = mpc;
    tick();
    start = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      chk("rand_req", 64'(imem_req), 64'd1);
      chk("rand_addr", 64'(imem_addr), 64'(mpc));
      w = mem[mpc];
      waits = int'($urandom_range(0, 3));
      for (int k = 0; k < waits; k++) begin
        imem_rdata = IW'($urandom);
        flags = 8'($urandom);
        tick();
      end
      imem_rdata = w;
      imem_ack = 1'b1;
      flags = 8'($urandom);
      tick();
      imem_rdata = IW'($urandom);
      imem_ack = 1'($urandom_range(0, 1));
      chk("rand_exec_en", 64'(exec_en), 64'd1);
      chk("rand_fields", dut_fields(), model_fields(w));
      f = 8'($urandom);
      flags = f;
      nxt = model_next_pc(mpc, w, f);
      tick();
      imem_ack = 1'b0;
      chk("rand_pc", 64'(pc), 64'(nxt));
      mpc = nxt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
